// File: rtl/screen_sequencer.sv
// Game-phase sequencer (START -> PLAY -> OVER) with frame-aligned switching and renderer pixel mux.
// pix_data lags the rgb inputs by 1 cycle; key edges reach the FSM 3 cycles after key_any rises; no backpressure.
module screen_sequencer #(
  parameter int HOLD_FRAMES = 120,
  parameter int CNT_W       = 8
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        key_any,
  input  logic        frame_tick,
  input  logic        game_over,
  input  logic [15:0] start_rgb,
  input  logic [15:0] play_rgb,
  input  logic [15:0] end_rgb,
  output logic [15:0] pix_data,
  output logic        game_rst_n,
  output logic        score_latch,
  output logic [1:0]  phase
);
  typedef enum logic [1:0] {
    PH_START = 2'd0,
    PH_PLAY  = 2'd1,
    PH_OVER  = 2'd2,
    PH_BAD   = 2'd3
  } phase_t;

  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             pending_q, pending_d;
  logic             key_s1_q, key_s2_q, key_s3_q, key_rise_q;
  logic [15:0]      pix_q, pix_d;
  logic             grn_q, grn_d;
  logic             latch_q, latch_d;
  logic             event_w;
  logic             advance_w;

  assign advance_w = frame_tick & pending_q;

  // Two flops tame the asynchronous key level; the third gives the previous value for edge detection.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_s1_q   <= 1'b0;
      key_s2_q   <= 1'b0;
      key_s3_q   <= 1'b0;
      key_rise_q <= 1'b0;
    end else begin
      key_s1_q   <= key_any;
      key_s2_q   <= key_s1_q;
      key_s3_q   <= key_s2_q;
      key_rise_q <= key_s2_q & ~key_s3_q;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      phase_q   <= PH_START;
      hold_q    <= '0;
      pending_q <= 1'b0;
      pix_q     <= '0;
      grn_q     <= 1'b0;
      latch_q   <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      pix_q     <= pix_d;
      grn_q     <= grn_d;
      latch_q   <= latch_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    hold_d  = hold_q;
    event_w = 1'b0;
    case (phase_q)
      PH_START: begin
        event_w = key_rise_q;
        if (advance_w) phase_d = PH_PLAY;
      end
      PH_PLAY: begin
        event_w = game_over;
        if (advance_w) begin
          phase_d = PH_OVER;
          hold_d  = CNT_W'(HOLD_FRAMES);
        end
      end
      PH_OVER: begin
        event_w = key_rise_q & (hold_q == '0);
        if (frame_tick && (hold_q != '0)) hold_d = hold_q - 1'b1;
        if (advance_w) phase_d = PH_START;
      end
      default: phase_d = PH_START;
    endcase

    // An event seen on the switching tick belongs to the old phase, so it must not leak into the new one.
    if (advance_w || (phase_q == PH_BAD)) pending_d = 1'b0;
    else if (frame_tick)                  pending_d = event_w;
    else                                  pending_d = pending_q | event_w;
  end

  always_comb begin
    pix_d   = '0;
    grn_d   = (phase_q == PH_PLAY);
    latch_d = (phase_q == PH_PLAY) && advance_w;
    case (phase_q)
      PH_START: pix_d = start_rgb;
      PH_PLAY:  pix_d = play_rgb;
      PH_OVER:  pix_d = end_rgb;
      default:  pix_d = '0;
    endcase
  end

  assign pix_data    = pix_q;
  assign game_rst_n  = grn_q;
  assign score_latch = latch_q;
  assign phase       = phase_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Scenario bench for screen_sequencer: per-scenario cycle tables, expectations queued then popped at sample time.
module tb_screen_sequencer;
  localparam logic [15:0] S = 16'h001F;
  localparam logic [15:0] P = 16'hF800;
  localparam logic [15:0] E = 16'h07E0;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n, key_any, frame_tick, game_over;
  logic [15:0] start_rgb, play_rgb, end_rgb, pix_data;
  logic        game_rst_n, score_latch;
  logic [1:0]  phase;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [1:0]  ph;
    logic [15:0] pix;
    logic        grn;
    logic        sl;
  } exp_t;

  // One table row: inputs held for rep cycles, then outputs compared.
  typedef struct packed {
    logic        k;
    logic        t;
    logic        g;
    logic [3:0]  rep;
    logic [1:0]  ph;
    logic [15:0] pix;
    logic        grn;
    logic        sl;
  } row_t;

  exp_t exp_q[$];
  exp_t ein, e;

  screen_sequencer #(.HOLD_FRAMES(3), .CNT_W(8)) dut (
    .vga_clk     (vga_clk),
    .sys_rst_n   (sys_rst_n),
    .key_any     (key_any),
    .frame_tick  (frame_tick),
    .game_over   (game_over),
    .start_rgb   (start_rgb),
    .play_rgb    (play_rgb),
    .end_rgb     (end_rgb),
    .pix_data    (pix_data),
    .game_rst_n  (game_rst_n),
    .score_latch (score_latch),
    .phase       (phase)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b1;
    #2 sys_rst_n = 1'b0;
    ein.ph = 2'd0; ein.pix = 16'h0000; ein.grn = 1'b0; ein.sl = 1'b0;
    exp_q.push_back(ein);
    #1;
    e = exp_q.pop_front();
    n_chk++; if (phase !== e.ph)        $display("FAIL reset phase got %0d want %0d", phase, e.ph); else n_pass++;
    n_chk++; if (pix_data !== e.pix)    $display("FAIL reset pix got %h want %h", pix_data, e.pix); else n_pass++;
    n_chk++; if (game_rst_n !== e.grn)  $display("FAIL reset game_rst_n got %b want %b", game_rst_n, e.grn); else n_pass++;
    n_chk++; if (score_latch !== e.sl)  $display("FAIL reset score_latch got %b want %b", score_latch, e.sl); else n_pass++;
    step(); step();
    sys_rst_n = 1'b1;
    ein.ph = 2'd0; ein.pix = S; ein.grn = 1'b0; ein.sl = 1'b0;
    exp_q.push_back(ein);
    step(); step();
    e = exp_q.pop_front();
    n_chk++; if (phase !== e.ph)       $display("FAIL post_reset phase got %0d want %0d", phase, e.ph); else n_pass++;
    n_chk++; if (pix_data !== e.pix)   $display("FAIL post_reset pix got %h want %h", pix_data, e.pix); else n_pass++;
    n_chk++; if (game_rst_n !== e.grn) $display("FAIL post_reset game_rst_n got %b want %b", game_rst_n, e.grn); else n_pass++;
  endtask

  task automatic test_start_to_play();
    row_t rows [9] = '{
      '{1'b1, 1'b0, 1'b0, 4'd3, 2'd0, S, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'd1, 2'd0, S, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 4'd4, 2'd0, S, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'd1, 2'd1, S, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 4'd1, 2'd1, P, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b0, 4'd2, 2'd1, P, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b0, 4'd5, 2'd1, P, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'd1, 2'd1, P, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b0, 4'd2, 2'd1, P, 1'b1, 1'b0}};
    foreach (rows[i]) begin
      key_any = rows[i].k; frame_tick = rows[i].t; game_over = rows[i].g;
      ein.ph = rows[i].ph; ein.pix = rows[i].pix; ein.grn = rows[i].grn; ein.sl = rows[i].sl;
      exp_q.push_back(ein);
      repeat (rows[i].rep) step();
      e = exp_q.pop_front();
      n_chk++; if (phase !== e.ph)       $display("FAIL start_play[%0d] phase got %0d want %0d", i, phase, e.ph); else n_pass++;
      n_chk++; if (pix_data !== e.pix)   $display("FAIL start_play[%0d] pix got %h want %h", i, pix_data, e.pix); else n_pass++;
      n_chk++; if (game_rst_n !== e.grn) $display("FAIL start_play[%0d] game_rst_n got %b want %b", i, game_rst_n, e.grn); else n_pass++;
      n_chk++; if (score_latch !== e.sl) $display("FAIL start_play[%0d] score_latch got %b want %b", i, score_latch, e.sl); else n_pass++;
    end
    key_any = 1'b0; frame_tick = 1'b0; game_over = 1'b0;
  endtask

  task automatic test_play_to_over();
    row_t rows [4] = '{
      '{1'b0, 1'b1, 1'b1, 4'd1, 2'd1, P, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b0, 4'd3, 2'd1, P, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b0, 4'd1, 2'd2, P, 1'b1, 1'b1},
      '{1'b0, 1'b0, 1'b0, 4'd1, 2'd2, E, 1'b0, 1'b0}};
    foreach (rows[i]) begin
      key_any = rows[i].k; frame_tick = rows[i].t; game_over = rows[i].g;
      ein.ph = rows[i].ph; ein.pix = rows[i].pix; ein.grn = rows[i].grn; ein.sl = rows[i].sl;
      exp_q.push_back(ein);
      repeat (rows[i].rep) step();
      e = exp_q.pop_front();
      n_chk++; if (phase !== e.ph)       $display("FAIL play_over[%0d] phase got %0d want %0d", i, phase, e.ph); else n_pass++;
      n_chk++; if (pix_data !== e.pix)   $display("FAIL play_over[%0d] pix got %h want %h", i, pix_data, e.pix); else n_pass++;
      n_chk++; if (game_rst_n !== e.grn) $display("FAIL play_over[%0d] game_rst_n got %b want %b", i, game_rst_n, e.grn); else n_pass++;
      n_chk++; if (score_latch !== e.sl) $display("FAIL play_over[%0d] score_latch got %b want %b", i, score_latch, e.sl); else n_pass++;
    end
    key_any = 1'b0; frame_tick = 1'b0; game_over = 1'b0;
  endtask

  task automatic test_over_hold();
    row_t rows [19] = '{
      '{1'b1, 1'b0, 1'b0, 4'd5, 2'd2, E, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 4'd2, 2'd2, E, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 4'd1, 2'd2, E, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 4'd5, 2'd2, E, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 4'd2, 2'd2, E, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 4'd1, 2'd2, E, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 4'd5, 2'd2, E, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 4'd2, 2'd2, E, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 4'd1, 2'd2, E, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 4'd3, 2'd2, E, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 4'd1, 2'd2, E, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b1, 4'd4, 2'd2, E, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b1, 4'd1, 2'd2, E, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 4'd2, 2'd2, E, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 4'd1, 2'd2, E, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 4'd5, 2'd2, E, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 4'd1, 2'd2, E, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 4'd1, 2'd0, E, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 4'd1, 2'd0, S, 1'b0, 1'b0}};
    foreach (rows[i]) begin
      key_any = rows[i].k; frame_tick = rows[i].t; game_over = rows[i].g;
      ein.ph = rows[i].ph; ein.pix = rows[i].pix; ein.grn = rows[i].grn; ein.sl = rows[i].sl;
      exp_q.push_back(ein);
      repeat (rows[i].rep) step();
      e = exp_q.pop_front();
      n_chk++; if (phase !== e.ph)       $display("FAIL over_hold[%0d] phase got %0d want %0d", i, phase, e.ph); else n_pass++;
      n_chk++; if (pix_data !== e.pix)   $display("FAIL over_hold[%0d] pix got %h want %h", i, pix_data, e.pix); else n_pass++;
      n_chk++; if (game_rst_n !== e.grn) $display("FAIL over_hold[%0d] game_rst_n got %b want %b", i, game_rst_n, e.grn); else n_pass++;
      n_chk++; if (score_latch !== e.sl) $display("FAIL over_hold[%0d] score_latch got %b want %b", i, score_latch, e.sl); else n_pass++;
    end
    key_any = 1'b0; frame_tick = 1'b0; game_over = 1'b0;
  endtask

  task automatic test_game_over_in_start();
    row_t rows [5] = '{
      '{1'b0, 1'b0, 1'b1, 4'd3, 2'd0, S, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b1, 4'd1, 2'd0, S, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b1, 4'd2, 2'd0, S, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 4'd1, 2'd0, S, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 4'd2, 2'd0, S, 1'b0, 1'b0}};
    foreach (rows[i]) begin
      key_any = rows[i].k; frame_tick = rows[i].t; game_over = rows[i].g;
      ein.ph = rows[i].ph; ein.pix = rows[i].pix; ein.grn = rows[i].grn; ein.sl = rows[i].sl;
      exp_q.push_back(ein);
      repeat (rows[i].rep) step();
      e = exp_q.pop_front();
      n_chk++; if (phase !== e.ph)       $display("FAIL go_in_start[%0d] phase got %0d want %0d", i, phase, e.ph); else n_pass++;
      n_chk++; if (score_latch !== e.sl) $display("FAIL go_in_start[%0d] score_latch got %b want %b", i, score_latch, e.sl); else n_pass++;
    end
    key_any = 1'b0; frame_tick = 1'b0; game_over = 1'b0;
  endtask

  task automatic test_key_hold();
    row_t rows [13] = '{
      '{1'b1, 1'b0, 1'b0, 4'd5, 2'd0, S, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'd1, 2'd1, S, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 4'd2, 2'd1, P, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b1, 4'd1, 2'd1, P, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'd1, 2'd2, P, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b0, 4'd1, 2'd2, E, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'd3, 2'd2, E, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 4'd2, 2'd2, E, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'd2, 2'd2, E, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 4'd3, 2'd2, E, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 4'd4, 2'd2, E, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'd1, 2'd0, E, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 4'd1, 2'd0, S, 1'b0, 1'b0}};
    foreach (rows[i]) begin
      key_any = rows[i].k; frame_tick = rows[i].t; game_over = rows[i].g;
      ein.ph = rows[i].ph; ein.pix = rows[i].pix; ein.grn = rows[i].grn; ein.sl = rows[i].sl;
      exp_q.push_back(ein);
      repeat (rows[i].rep) step();
      e = exp_q.pop_front();
      n_chk++; if (phase !== e.ph)       $display("FAIL key_hold[%0d] phase got %0d want %0d", i, phase, e.ph); else n_pass++;
      n_chk++; if (pix_data !== e.pix)   $display("FAIL key_hold[%0d] pix got %h want %h", i, pix_data, e.pix); else n_pass++;
      n_chk++; if (game_rst_n !== e.grn) $display("FAIL key_hold[%0d] game_rst_n got %b want %b", i, game_rst_n, e.grn); else n_pass++;
      n_chk++; if (score_latch !== e.sl) $display("FAIL key_hold[%0d] score_latch got %b want %b", i, score_latch, e.sl); else n_pass++;
    end
    key_any = 1'b0; frame_tick = 1'b0; game_over = 1'b0;
  endtask

  task automatic test_async_reset();
    row_t rows [9] = '{
      '{1'b1, 1'b0, 1'b0, 4'd4, 2'd0, S, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 4'd1, 2'd1, S, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 4'd2, 2'd1, P, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b0, 4'd3, 2'd0, S, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 4'd1, 2'd0, S, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 4'd2, 2'd0, S, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 4'd4, 2'd0, S, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 4'd1, 2'd1, S, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 4'd1, 2'd1, P, 1'b1, 1'b0}};
    foreach (rows[i]) begin
      if (i == 3) begin
        // Mid-cycle assert: outputs must clear before any clock edge.
        #2 sys_rst_n = 1'b0;
        ein.ph = 2'd0; ein.pix = 16'h0000; ein.grn = 1'b0; ein.sl = 1'b0;
        exp_q.push_back(ein);
        #1;
        e = exp_q.pop_front();
        n_chk++; if (phase !== e.ph)       $display("FAIL async_rst phase got %0d want %0d", phase, e.ph); else n_pass++;
        n_chk++; if (pix_data !== e.pix)   $display("FAIL async_rst pix got %h want %h", pix_data, e.pix); else n_pass++;
        n_chk++; if (game_rst_n !== e.grn) $display("FAIL async_rst game_rst_n got %b want %b", game_rst_n, e.grn); else n_pass++;
        step(); step();
        sys_rst_n = 1'b1;
      end
      key_any = rows[i].k; frame_tick = rows[i].t; game_over = rows[i].g;
      ein.ph = rows[i].ph; ein.pix = rows[i].pix; ein.grn = rows[i].grn; ein.sl = rows[i].sl;
      exp_q.push_back(ein);
      repeat (rows[i].rep) step();
      e = exp_q.pop_front();
      n_chk++; if (phase !== e.ph)       $display("FAIL async_seq[%0d] phase got %0d want %0d", i, phase, e.ph); else n_pass++;
      n_chk++; if (pix_data !== e.pix)   $display("FAIL async_seq[%0d] pix got %h want %h", i, pix_data, e.pix); else n_pass++;
      n_chk++; if (game_rst_n !== e.grn) $display("FAIL async_seq[%0d] game_rst_n got %b want %b", i, game_rst_n, e.grn); else n_pass++;
    end
    key_any = 1'b0; frame_tick = 1'b0; game_over = 1'b0;
  endtask

  initial begin
    sys_rst_n  = 1'b1;
    key_any    = 1'b0;
    frame_tick = 1'b0;
    game_over  = 1'b0;
    start_rgb  = S;
    play_rgb   = P;
    end_rgb    = E;
    test_reset();
    test_start_to_play();
    test_play_to_over();
    test_over_hold();
    test_game_over_in_start();
    test_key_hold();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
- Top-level screen/game-phase controller between the renderers (page_start, vga_draw, page_end) and vga_ctrl.
- Runs the START -> PLAY -> OVER phase machine from key presses and game_over.
- Holds the game logic in reset outside PLAY.
- Selects which renderer's pixel stream drives vga_ctrl pix_data. Phase changes occur only at frame boundaries so no frame tears.

Parameters:
- HOLD_FRAMES, 120, number of frames OVER is shown before a key press is accepted; must be >= 1.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > HOLD_FRAMES.

Ports:
- vga_clk  input  1  pixel clock, 25 MHz.
- sys_rst_n  input  1  asynchronous active-low reset.
- key_any  input  1  OR of the four raw key levels, active-high, asynchronous to vga_clk.
- frame_tick  input  1  one-cycle pulse at the first cycle of vertical blanking, once per frame.
- game_over  input  1  level from game_logic, synchronous to vga_clk.
- start_rgb  input  16  RGB565 from page_start.
- play_rgb  input  16  RGB565 from vga_draw.
- end_rgb  input  16  RGB565 from page_end.
- pix_data  output  16  selected RGB565 to vga_ctrl.
- game_rst_n  output  1  active-low reset to game_logic.
- score_latch  output  1  one-cycle pulse telling page_end to freeze the score.
- phase  output  2  current phase: 0 START, 1 PLAY, 2 OVER.

Behaviour:
- Reset (asynchronous assert, synchronous release via sys_rst_n): all registers clear.
  - phase = 0 (START), pix_data = 0, game_rst_n = 0, score_latch = 0, pending = 0, hold counter = 0, synchroniser = 0.
- Key input path:
  - key_any passes a 2-flop synchroniser, then a rising-edge detector.
  - key_rise is a 1-cycle pulse, 3 cycles after the input edge.
  - Holding the key generates no further pulses.
- pending flag:
  - Set by a qualifying event (defined per state below).
  - Cleared on every frame_tick.
  - A state transition occurs on a frame_tick only if pending was already 1 in the previous cycle.
  - An event coinciding with frame_tick keeps pending = 1, so its transition occurs on the next tick.
- START:
  - key_rise sets pending.
  - frame_tick with pending -> PLAY.
- PLAY:
  - game_over = 1 sets pending. Key presses are ignored.
  - frame_tick with pending -> OVER; hold counter loaded with HOLD_FRAMES; score_latch = 1 in that same cycle.
- OVER:
  - Each frame_tick decrements the hold counter while it is nonzero; the counter saturates at 0.
  - key_rise sets pending only when the counter is 0. Presses while the counter is nonzero are dropped, not queued.
  - frame_tick with pending -> START.
- Illegal phase encoding 3: returns to START at the next clock with game_rst_n = 0.
- game_rst_n:
  - Registered.
  - Equals 1 exactly when phase == PLAY; changes in the cycle after phase changes.
  - game_logic is therefore held in reset throughout START and OVER and released on the first PLAY frame.
- pix_data:
  - Registered mux with 1-cycle latency from the rgb inputs.
  - Selection uses the current phase: START -> start_rgb, PLAY -> play_rgb, OVER -> end_rgb, illegal -> 0.
  - All three renderers must have equal latency to this point.
- game_over is sampled only in PLAY; its level in other phases has no effect.
- Reset mid-frame or mid-hold returns immediately to the reset values above. There is no memory of the prior phase.

Test Plan:
- Reset, then key_any = 1 at cycle 10, frame_tick at cycle 50 -> key_rise at cycle 13; phase goes 0 -> 1 at cycle 51; game_rst_n goes 1 at cycle 52; pix_data follows play_rgb = 16'hF800 with 1-cycle latency.
- In PLAY, game_over = 1 in the same cycle as frame_tick -> phase stays 1 for that tick and becomes 2 after the following tick. score_latch is high for exactly 1 cycle; game_rst_n is 0 one cycle later.
- OVER with HOLD_FRAMES = 3: keys pressed during ticks 1-2 -> no transition. Key pressed after the 3rd tick, then the next tick -> phase 0. pix_data switches from end_rgb = 16'h07E0 to start_rgb = 16'h001F.
- key_any held high for 5 frames in START, then released and pressed again -> only one pending set per press; the phase advances once per press.
- Assert sys_rst_n = 0 mid-PLAY at an arbitrary pixel -> pix_data = 0, phase = 0, game_rst_n = 0 with no clock edge required. After release, a key press is needed to re-enter PLAY.
- Toggle game_over while in START and OVER -> phase and score_latch are unchanged.
